// File: rtl/rr_fifo_arbiter_pkg.sv
// rr_fifo_arbiter shared types and defaults
// state encodings, default sizes, dest-field extraction macro
package rr_fifo_arbiter_pkg;

  localparam int NUM_FIFOS_DEF      = 4;
  localparam int NUM_OUT_DEF        = 4;
  localparam int FIFO_WORD_SIZE_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACTIVE = 3'b010,
    ST_STALL  = 3'b100
  } arb_state_e;

endpackage

`define ARB_DEST(word, w, d) word[(w)-1 -: (d)]

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate-and-priority-encode
// first request found after ptr, wrapping modulo N
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan ptr+1 .. ptr+N, first hit wins
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin input-to-output FIFO scheduler
// ARB_WORD_COUNT_EN adds per-output 8-bit push counters (out_count)
module rr_fifo_arbiter
  import rr_fifo_arbiter_pkg::*;
#(
  parameter int NUM_FIFOS      = NUM_FIFOS_DEF,
  parameter int NUM_OUT        = NUM_OUT_DEF,
  parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
  parameter int DEST_SIZE      = $clog2(NUM_OUT),
  parameter int IDX_SIZE       = $clog2(NUM_FIFOS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_FIFOS-1:0]                in_empty,
  input  logic [NUM_FIFOS*FIFO_WORD_SIZE-1:0] in_data,
  input  logic [NUM_OUT-1:0]                  out_almost_full,
  output logic [NUM_FIFOS-1:0]                in_pop,
  output logic [NUM_OUT-1:0]                  out_push,
  output logic [FIFO_WORD_SIZE-1:0]           out_data,
  output logic [IDX_SIZE-1:0]                 grant_idx,
`ifdef ARB_WORD_COUNT_EN
  output logic [NUM_OUT*8-1:0]                out_count,
`endif
  output logic                                idle,
  output logic                                stall
);

  logic [FIFO_WORD_SIZE-1:0] words [NUM_FIFOS];
  logic [DEST_SIZE-1:0]      dests [NUM_FIFOS];
  logic [NUM_FIFOS-1:0]      elig;
  logic [NUM_FIFOS-1:0]      gnt;
  logic [IDX_SIZE-1:0]       gidx;
  logic                      any;
  logic [IDX_SIZE-1:0]       ptr;
  arb_state_e                state;
  arb_state_e                nxt;

  // split heads, extract dests, qualify requests
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      words[i] = in_data[i*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
      dests[i] = `ARB_DEST(words[i], FIFO_WORD_SIZE, DEST_SIZE);
      elig[i]  = enable && !in_empty[i]
              && !out_almost_full[dests[i]];
    end
  end

  rr_priority_pick #(
    .N  (NUM_FIFOS),
    .IW (IDX_SIZE)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign in_pop = reset ? '0 : gnt;

  // next-state decode from request/grant status
  always_comb begin
    nxt = ST_STALL;
    if (&in_empty || !enable)
      nxt = ST_IDLE;
    else if (any)
      nxt = ST_ACTIVE;
  end

  // state, pointer and push stage; reset drops the staged word
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= IDX_SIZE'(NUM_FIFOS-1);
      out_push  <= '0;
      out_data  <= '0;
      grant_idx <= '0;
      idle      <= 1'b1;
      stall     <= 1'b0;
    end else begin
      state    <= nxt;
      idle     <= (nxt == ST_IDLE);
      stall    <= (nxt == ST_STALL);
      out_push <= '0;
      if (any) begin
        ptr       <= gidx;
        out_push  <= NUM_OUT'(1) << dests[gidx];
        out_data  <= words[gidx];
        grant_idx <= gidx;
      end
    end
  end

`ifdef ARB_WORD_COUNT_EN
  logic [7:0] cnt_q [NUM_OUT];

  // per-output push counters, wrap at 255
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OUT; k++) begin
      if (reset)
        cnt_q[k] <= 8'd0;
      else if (out_push[k])
        cnt_q[k] <= cnt_q[k] + 8'd1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
    assign out_count[k*8 +: 8] = cnt_q[k];
  end
`endif

endmodule

// File: doc/rr_fifo_arbiter.md
Name: rr_fifo_arbiter

Overview:
- Transaction-layer scheduler between NUM_FIFOS input FIFOs and NUM_OUT output FIFOs.
- Round-robin pick of one non-empty input FIFO per cycle; pops its head word and pushes it, one cycle later, to the output FIFO selected by the word's destination field.
- Output FIFO almost_full flags provide backpressure; thresholds are programmed by the config FSM.
- Reports idle/stall status to that FSM.

Parameters:
- NUM_FIFOS, 4, number of input FIFOs (requesters).
- NUM_OUT, 4, number of output FIFOs; power of 2.
- FIFO_WORD_SIZE, 10, word width in bits.
- DEST_SIZE, $clog2(NUM_OUT), destination field width; field = word[FIFO_WORD_SIZE-1 -: DEST_SIZE].
- IDX_SIZE, $clog2(NUM_FIFOS), grant index width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  from config FSM; grants are allowed only while high.
- in_empty  in  NUM_FIFOS  empty flag per input FIFO.
- in_data  in  NUM_FIFOS*FIFO_WORD_SIZE  head word per input FIFO (first-word fall-through); FIFO i occupies bits [i*W +: W].
- out_almost_full  in  NUM_OUT  almost-full flag per output FIFO.
- in_pop  out  NUM_FIFOS  one-hot pop strobe, combinational, same cycle as grant.
- out_push  out  NUM_OUT  one-hot push strobe, registered.
- out_data  out  FIFO_WORD_SIZE  word being pushed, registered.
- grant_idx  out  IDX_SIZE  index of the last granted input, registered.
- idle  out  1  registered; 1 when state is IDLE.
- stall  out  1  registered; 1 when state is STALL.

Behaviour:
- Eligibility: input i is eligible iff enable && !in_empty[i] && !out_almost_full[dest(in_data_i)].
- Search: start at ptr+1 and wrap modulo NUM_FIFOS. The first eligible input i is granted: in_pop[i]=1 this cycle, and ptr <= i.
- At most one pop per cycle. No grant leaves in_pop = 0 and ptr unchanged.
- Pipeline, latency 1 cycle: on grant at cycle N, at cycle N+1 out_data holds the popped word, out_push[dest]=1, and grant_idx=i. With no grant at N, out_push=0 at N+1 and out_data holds its last value.
- Back-to-back grants are allowed every cycle. Output FIFO almost_full thresholds must leave at least 1 word of slack because of the pipeline stage.
- State register values are IDLE, ACTIVE and STALL. The next state is computed every cycle:
  - all in_empty=1, or enable=0 -> IDLE.
  - grant issued -> ACTIVE.
  - some input non-empty but none eligible -> STALL.
- idle = (state==IDLE); stall = (state==STALL).
- Reset, including mid-operation, takes effect at the next posedge:
  - state=IDLE, ptr=NUM_FIFOS-1 (so the first search starts at input 0).
  - out_push=0, out_data=0, grant_idx=0.
  - idle=1, stall=0.
  - Any word in the pipeline stage is dropped with no push.
  - in_pop is forced to 0 while reset=1.
- Simultaneous events:
  - Almost_full rising in the same cycle as a grant does not cancel the push already in flight.
  - enable falling blocks new grants that cycle; a word already popped is still pushed on the next cycle.
- A single eligible input gets every cycle. N eligible inputs are each served once per N cycles.

Optional Feature:
- Macro ARB_WORD_COUNT_EN.
- Defined:
  - Adds output port out_count, NUM_OUT*8 bits.
  - One 8-bit counter per output FIFO, incremented on each out_push.
  - Wraps 255->0; cleared by reset.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - the state encodings, one-hot 1/2/4 for IDLE/ACTIVE/STALL;
  - NUM_FIFOS, NUM_OUT and FIFO_WORD_SIZE defaults;
  - a dest-field extraction macro.
- One natural sub-module, rr_priority_pick: combinational rotate-and-priority-encode over a NUM_FIFOS request vector plus a start pointer. It returns a grant one-hot and index.

Test Plan:
- Reset with all empty -> idle=1, stall=0, in_pop=0, out_push=0. Release reset with FIFO 0 non-empty, dest=2 -> in_pop=0001, then next cycle out_push=0100, out_data=word, grant_idx=0.
- FIFOs 0-3 non-empty continuously, no backpressure -> pops 0,1,2,3,0,… on consecutive cycles; state ACTIVE.
- FIFOs 1 and 2 non-empty; FIFO 1 head dest=3 with out_almost_full[3]=1 -> only FIFO 2 is granted. With all heads blocked -> stall=1 and no pops. Dropping almost_full -> resume within 1 cycle.
- Assert reset the cycle after a grant -> no out_push next cycle, ptr restarts, and the first grant after release goes to input 0.
- enable=0 with non-empty FIFOs -> no pops and idle=1. Raise enable -> grant in the same cycle.
- With ARB_WORD_COUNT_EN defined: push 260 words to dest 1 -> out_count[15:8]=4 and the other counters stay 0.
